// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl
//   Watch user-interface controller. Converts four debounced, clock-synchronous
//   button levels into display mode, stopwatch control and per-field
//   time-adjust pulses, with press-edge detection, hold-to-repeat in SET and
//   a SET-mode inactivity timeout.
//
// Ports
//   clk_i               system clock, rising edge
//   reset_n_i           asynchronous active-low reset
//   btn_mode_i          mode button level
//   btn_time_set_i      time-set button level
//   btn_increment_i     increment button level
//   btn_decrement_i     decrement button level
//   mode_o              00 TIME, 01 STOPWATCH, 10 SET
//   field_sel_o         field being set (0 outside SET)
//   inc_o / dec_o       one-cycle adjust pulse, one bit per field
//   run_time_o          timekeeping enable (low only in SET)
//   run_stopwatch_o     stopwatch enable
//   reset_stopwatch_o   one-cycle stopwatch clear pulse
module watch_mode_ctrl #(
  parameter int NUM_FIELDS    = 2,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  btn_mode_i,
  input  logic                  btn_time_set_i,
  input  logic                  btn_increment_i,
  input  logic                  btn_decrement_i,
  output logic [1:0]            mode_o,
  output logic [2:0]            field_sel_o,
  output logic [NUM_FIELDS-1:0] inc_o,
  output logic [NUM_FIELDS-1:0] dec_o,
  output logic                  run_time_o,
  output logic                  run_stopwatch_o,
  output logic                  reset_stopwatch_o
);

  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    M_TIME = 2'b00,
    M_SW   = 2'b01,
    M_SET  = 2'b10
  } mode_e;

  mode_e                 mode_q, mode_d;
  logic [2:0]            field_q, field_d;
  logic [NUM_FIELDS-1:0] inc_q, inc_d, dec_q, dec_d;
  logic                  run_sw_q, run_sw_d;
  logic                  rst_sw_q, rst_sw_d;
  logic [3:0]            btn_q;                 // {dec, inc, time_set, mode}
  logic [RW-1:0]         rep_cnt_q, rep_cnt_d;  // edges since last pulse; 0 = repeat disarmed
  logic                  rep_per_q, rep_per_d;  // 0: waiting first delay, 1: periodic phase
  logic [IW-1:0]         idle_q, idle_d;

  logic [3:0]            btn, press;
  logic                  fire;
  logic [RW-1:0]         rep_limit;
  logic [NUM_FIELDS-1:0] field_onehot;

  assign btn          = {btn_decrement_i, btn_increment_i, btn_time_set_i, btn_mode_i};
  assign press        = btn & ~btn_q;
  assign rep_limit    = rep_per_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
  assign field_onehot = NUM_FIELDS'(1) << field_q;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode_q    <= M_TIME;
      field_q   <= '0;
      inc_q     <= '0;
      dec_q     <= '0;
      run_sw_q  <= 1'b0;
      rst_sw_q  <= 1'b0;
      btn_q     <= '1;  // a button held through reset release is not a press
      rep_cnt_q <= '0;
      rep_per_q <= 1'b0;
      idle_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      field_q   <= field_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      run_sw_q  <= run_sw_d;
      rst_sw_q  <= rst_sw_d;
      btn_q     <= btn;
      rep_cnt_q <= rep_cnt_d;
      rep_per_q <= rep_per_d;
      idle_q    <= idle_d;
    end
  end

  // Next-state logic
  always_comb begin
    mode_d    = mode_q;
    field_d   = field_q;
    inc_d     = '0;
    dec_d     = '0;
    run_sw_d  = run_sw_q;
    rst_sw_d  = 1'b0;
    rep_cnt_d = '0;
    rep_per_d = 1'b0;
    idle_d    = '0;
    fire      = 1'b0;
    case (mode_q)
      M_TIME: begin
        if (press[0]) begin
          mode_d = M_SW;
        end else if (press[1]) begin
          mode_d  = M_SET;
          field_d = 3'(NUM_FIELDS - 1);
        end
      end
      M_SW: begin
        if (press[2]) begin
          run_sw_d = ~run_sw_q;
        end else if (press[3]) begin
          rst_sw_d = 1'b1;
          run_sw_d = 1'b0;
        end else if (press[0]) begin
          mode_d = M_TIME;
        end
      end
      M_SET: begin
        // Mode/field changes leave the repeat counter at 0, so a still-held
        // button cannot repeat until it is released and pressed again.
        if (press[0]) begin
          mode_d  = M_TIME;
          field_d = '0;
        end else if (press[1]) begin
          if (field_q == '0) mode_d = M_TIME;
          else               field_d = field_q - 3'd1;
        end else if (btn[2] && btn[3]) begin
          rep_cnt_d = '0;
        end else if (press[2] || press[3]) begin
          fire      = 1'b1;
          rep_cnt_d = RW'(1);
        end else if ((btn[2] || btn[3]) && rep_cnt_q != '0) begin
          if (rep_cnt_q == rep_limit) begin
            fire      = 1'b1;
            rep_cnt_d = RW'(1);
            rep_per_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
            rep_per_d = rep_per_q;
          end
        end

        // Only one of inc/dec can be held when fire is set.
        if (fire) begin
          if (btn[2]) inc_d = field_onehot;
          else        dec_d = field_onehot;
        end

        if ((|press) || fire) begin
          idle_d = '0;
        end else if (idle_q == IW'(TIMEOUT - 1)) begin
          mode_d  = M_TIME;
          field_d = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: begin
        mode_d  = M_TIME;
        field_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    mode_o            = mode_q;
    field_sel_o       = field_q;
    inc_o             = inc_q;
    dec_o             = dec_q;
    run_time_o        = (mode_q != M_SET);
    run_stopwatch_o   = run_sw_q;
    reset_stopwatch_o = rst_sw_q;
  end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
module tb_watch_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bm = 1'b0, bt = 1'b0, bi = 1'b0, bd = 1'b0;
  logic [1:0] mode;
  logic [2:0] field_sel;
  logic [2:0] inc, dec;
  logic       run_time, run_sw, rst_sw;

  int checks = 0;
  int failures = 0;

  watch_mode_ctrl #(
    .NUM_FIELDS(3), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .TIMEOUT(64)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .btn_mode_i(bm), .btn_time_set_i(bt), .btn_increment_i(bi), .btn_decrement_i(bd),
    .mode_o(mode), .field_sel_o(field_sel), .inc_o(inc), .dec_o(dec),
    .run_time_o(run_time), .run_stopwatch_o(run_sw), .reset_stopwatch_o(rst_sw)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with mode button held
    bm = 1'b1;
    #12;
    chk("rst_mode", 8'(mode), 8'h0);
    chk("rst_field", 8'(field_sel), 8'h0);
    chk("rst_inc", 8'(inc), 8'h0);
    chk("rst_dec", 8'(dec), 8'h0);
    chk("rst_run_time", 8'(run_time), 8'h1);
    chk("rst_run_sw", 8'(run_sw), 8'h0);
    chk("rst_rst_sw", 8'(rst_sw), 8'h0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("held_no_press", 8'(mode), 8'h0);
    bm = 1'b0; tick();
    chk("release_no_press", 8'(mode), 8'h0);
    bm = 1'b1; tick();
    chk("fresh_press_sw", 8'(mode), 8'h1);
    bm = 1'b0; tick();

    // Stopwatch control
    bi = 1'b1; tick();
    chk("sw_start", 8'(run_sw), 8'h1);
    chk("sw_start_nopulse", 8'(rst_sw), 8'h0);
    bi = 1'b0; tick(); tick();
    bd = 1'b1; tick();
    chk("sw_clr_pulse", 8'(rst_sw), 8'h1);
    chk("sw_clr_stop", 8'(run_sw), 8'h0);
    bd = 1'b0; tick();
    chk("sw_clr_one_cycle", 8'(rst_sw), 8'h0);
    bi = 1'b1; tick();
    chk("sw_restart", 8'(run_sw), 8'h1);
    bi = 1'b0; tick();
    bm = 1'b1; tick();
    chk("sw_to_time", 8'(mode), 8'h0);
    chk("sw_runs_hidden", 8'(run_sw), 8'h1);
    bm = 1'b0; tick();

    // Field walk with an inc press per field
    bt = 1'b1; tick();
    chk("set_enter", 8'(mode), 8'h2);
    chk("set_field2", 8'(field_sel), 8'h2);
    chk("set_run_time", 8'(run_time), 8'h0);
    chk("set_sw_running", 8'(run_sw), 8'h1);
    bt = 1'b0; tick();
    bi = 1'b1; tick();
    chk("inc_f2", 8'(inc), 8'h4);
    bi = 1'b0; tick();
    chk("inc_f2_one", 8'(inc), 8'h0);
    bt = 1'b1; tick();
    chk("set_field1", 8'(field_sel), 8'h1);
    bt = 1'b0; tick();
    bi = 1'b1; tick();
    chk("inc_f1", 8'(inc), 8'h2);
    bi = 1'b0; tick();
    bt = 1'b1; tick();
    chk("set_field0", 8'(field_sel), 8'h0);
    bt = 1'b0; tick();
    bi = 1'b1; tick();
    chk("inc_f0", 8'(inc), 8'h1);
    bi = 1'b0; tick();
    bd = 1'b1; tick();
    chk("dec_f0", 8'(dec), 8'h1);
    chk("dec_f0_noinc", 8'(inc), 8'h0);
    bd = 1'b0; tick();
    bt = 1'b1; tick();
    chk("set_exit_field0", 8'(mode), 8'h0);
    chk("set_exit_run_time", 8'(run_time), 8'h1);
    bt = 1'b0; tick();

    // Auto-repeat on field 1
    bt = 1'b1; tick(); bt = 1'b0; tick();
    bt = 1'b1; tick(); bt = 1'b0; tick();
    chk("rep_field1", 8'(field_sel), 8'h1);
    bi = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      chk($sformatf("rep_k%0d", k), 8'(inc),
          (k == 0 || k == 8 || k == 12 || k == 16 || k == 20) ? 8'h2 : 8'h0);
    end
    bi = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rep_after_release", 8'(inc), 8'h0);
    end
    bm = 1'b1; tick();
    chk("rep_exit", 8'(mode), 8'h0);
    bm = 1'b0; tick();

    // Inactivity timeout
    bt = 1'b1; tick();
    chk("to_enter", 8'(mode), 8'h2);
    bt = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k >= 60) chk($sformatf("to_k%0d", k), 8'(mode), (k < 64) ? 8'h2 : 8'h0);
    end
    chk("to_field_clr", 8'(field_sel), 8'h0);

    // Holding inc keeps SET alive
    bt = 1'b1; tick();
    bt = 1'b0; bi = 1'b1; tick();
    chk("hold_first_pulse", 8'(inc), 8'h4);
    for (int k = 0; k < 100; k++) tick();
    chk("hold_keeps_set", 8'(mode), 8'h2);
    bi = 1'b0; bm = 1'b1; tick();
    chk("hold_exit", 8'(mode), 8'h0);
    bm = 1'b0; tick();

    // inc and dec pressed together
    bt = 1'b1; tick(); bt = 1'b0; tick();
    bi = 1'b1; bd = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("both_inc", 8'(inc), 8'h0);
      chk("both_dec", 8'(dec), 8'h0);
    end
    bd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("dec_released_inc", 8'(inc), 8'h0);
      chk("dec_released_dec", 8'(dec), 8'h0);
    end
    bi = 1'b0; tick();
    bi = 1'b1; tick();
    chk("inc_repress", 8'(inc), 8'h4);
    tick(); tick();

    // Asynchronous reset mid-SET with inc held
    rst_n = 1'b0; #1;
    chk("async_rst_mode", 8'(mode), 8'h0);
    chk("async_rst_run_sw", 8'(run_sw), 8'h0);
    chk("async_rst_field", 8'(field_sel), 8'h0);
    #3; rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_inc", 8'(inc), 8'h0);
      chk("post_rst_mode", 8'(mode), 8'h0);
    end
    bi = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
- Parametrised next-generation watch user-interface controller. Turns four debounced, clk-synchronous button levels into mode state, stopwatch control and per-field time-adjust pulses.
- Adds over the previous controller:
  - N settable time fields.
  - Internal press-edge detection.
  - Hold-to-auto-repeat.
  - Set-mode inactivity timeout.
  - Stopwatch run state kept independently of display mode.
- Sits between the button front end and the timekeeping counters / 7-segment controller.

Parameters:
- NUM_FIELDS, 2, number of settable fields (field NUM_FIELDS-1 = most significant, e.g. hours); legal 1..8
- REPEAT_DELAY, 8, cycles a held inc/dec button waits after its press pulse before the first repeat pulse; ≥2
- REPEAT_PERIOD, 4, cycles between repeat pulses; ≥1
- TIMEOUT, 64, consecutive event-free cycles in SET before automatic exit; ≥2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- btn_mode  in  1  debounced, synchronous level
- btn_time_set  in  1  debounced, synchronous level
- btn_increment  in  1  debounced, synchronous level
- btn_decrement  in  1  debounced, synchronous level
- mode  out  2  00 TIME, 01 STOPWATCH, 10 SET (11 never driven)
- field_sel  out  3  field being set; valid in SET, 0 otherwise
- inc  out  NUM_FIELDS  one-cycle increment pulse, bit = field
- dec  out  NUM_FIELDS  one-cycle decrement pulse, bit = field
- run_time  out  1  timekeeping enable
- run_stopwatch  out  1  stopwatch enable
- reset_stopwatch  out  1  one-cycle stopwatch clear pulse

Behaviour:
- Reset (reset_n low, async):
  - mode=TIME, field_sel=0, inc=0, dec=0, run_stopwatch=0, reset_stopwatch=0, run_time=1.
  - Button history registers are set to 1, so a button held through reset release gives no press.
  - All counters are cleared.
- Press event: btn=1 and previous sampled value=0, detected at a clk edge. All outputs are registered; a response appears in the cycle after the detecting edge.
- run_time = 0 in SET, 1 otherwise (combinational from the mode register is acceptable).
- TIME:
  - mode press → STOPWATCH.
  - Else time_set press → SET with field_sel=NUM_FIELDS-1.
  - inc/dec ignored.
- STOPWATCH (priority inc > dec > mode; one action per edge):
  - inc press toggles run_stopwatch.
  - dec press: reset_stopwatch pulses for 1 cycle and run_stopwatch clears.
  - mode press → TIME.
  - time_set ignored.
- run_stopwatch persists across TIME/SET; the stopwatch keeps running while hidden or while setting.
- SET (priority mode > time_set > inc/dec):
  - mode press → TIME (edits kept).
  - time_set press: field_sel decrements; at field_sel=0 → TIME.
  - inc press, dec not held: inc[field_sel] pulses.
  - dec press, inc not held: dec[field_sel] pulses.
  - inc and dec both high: no pulses, repeat counter held at 0.
- Auto-repeat:
  - While the same button stays held in SET with no field/mode change, further pulses occur at press edge t0+REPEAT_DELAY, then every REPEAT_PERIOD edges.
  - Release clears the repeat counter.
  - Any field_sel or mode change suppresses repeat until that button is released.
- Timeout:
  - The idle counter counts edges in SET with no press event and no inc/dec pulse issued.
  - Any press or pulse clears it.
  - When the count reaches TIMEOUT → TIME, idle counter cleared.
  - A mode/time_set press on the same edge takes precedence.
- Only one inc or dec bit is ever high, never both. No pulses outside SET.
- reset_n assertion mid-repeat or mid-SET aborts immediately to reset values; no pulse is emitted on release.

Test Plan:
- Reset release with btn_mode held high, then release, then press → no transition until the fresh press; then mode=01 the cycle after the detecting edge.
- In STOPWATCH, press inc, later press dec:
  - run_stopwatch=1 after the first press.
  - On the dec press, reset_stopwatch=1 for exactly one cycle and run_stopwatch=0.
  - Press mode → TIME; a toggle before leaving leaves run_stopwatch=1 in TIME.
- NUM_FIELDS=3, TIME, three time_set presses → field_sel 2, 1, 0, then mode=00; inc press at each field → inc=100, 010, 001 respectively.
- SET, field 1, hold inc for 20 cycles (defaults) → inc[1] pulses at press edge offsets 0, 8, 12, 16, 20; none after release.
- SET, no presses for 64 cycles → mode returns to 00 exactly at the 64th idle edge. Holding inc throughout instead keeps SET active.
- inc and dec pressed on the same edge in SET → inc=dec=0 throughout. Releasing dec then yields no pulse until inc is re-pressed.
